// File: rtl/pio_pkg.sv
// Shared types for the PIO host controller: FSM states, PIO command codes, push record.
package pio_pkg;
  localparam int NUM_SM = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD_PROG, ST_LOAD_CONF, ST_RUN} state_t;

  typedef enum logic [3:0] {ACT_NONE = 4'd0, ACT_INSTR = 4'd1, ACT_PUSH = 4'd4} pio_act_e;

  typedef struct packed {
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic [31:0] din;
  } push_cmd_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] len, input int max_len);
    return (int'(len) > max_len) ? 6'(max_len) : len;
  endfunction
endpackage

// File: rtl/pio_rr_arb.sv
// 4-way round-robin arbiter; priority starts at the requester after the last winner.
module pio_rr_arb
  import pio_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       i_en,
  input  logic [3:0] i_req,
  input  logic [3:0] i_mask,
  output logic [3:0] o_gnt,
  output logic [1:0] o_win
);
  logic [1:0] r_ptr;
  logic [3:0] w_elig;
  logic [3:0] w_gnt;
  logic [1:0] w_win;
  logic [1:0] w_idx;

  assign w_elig = i_req & ~i_mask & {4{i_en}};

  // Scan from lowest priority up so the highest-priority hit is written last.
  always_comb begin
    w_gnt = '0;
    w_win = r_ptr;
    w_idx = '0;
    for (int off = NUM_SM - 1; off >= 0; off--) begin
      w_idx = r_ptr + 2'(off);
      if (w_elig[w_idx]) begin
        w_gnt        = '0;
        w_gnt[w_idx] = 1'b1;
        w_win        = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)    r_ptr <= '0;
    else if (|w_gnt) r_ptr <= w_win + 2'd1;
  end

  assign o_gnt = w_gnt;
  assign o_win = w_win;
endmodule

// File: rtl/pio_host_ctrl.sv
// Loads PIO instruction and config ROMs over the command bus, then arbitrates TX pushes.
module pio_host_ctrl
  import pio_pkg::*;
#(
  parameter int PROG_LEN = 32,
  parameter int MAX_CONF = 32
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  output logic [4:0]   prog_addr,
  input  logic [15:0]  prog_data,
  output logic [4:0]   conf_addr,
  input  logic [35:0]  conf_data,
  input  logic [5:0]   conf_len,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  output logic [3:0]   gnt,
  input  logic [3:0]   tx_full,
  output logic [3:0]   action,
  output logic [4:0]   index,
  output logic [1:0]   mindex,
  output logic [31:0]  din,
  output logic         ready
);
  state_t               r_state, w_next;
  logic [5:0]           r_cnt;
  logic [5:0]           r_conf_len;
  logic [4:0]           r_prog_addr, r_conf_addr;
  logic [3:0]           r_gnt;
  push_cmd_t            r_push;
  logic [3:0][31:0]     w_words;
  logic [3:0]           w_arb_gnt;
  logic [1:0]           w_win;
  logic                 w_prog_last, w_conf_last, w_run_en;

  assign w_words     = req_data;
  assign w_prog_last = (r_state == ST_LOAD_PROG) && (r_cnt == 6'(PROG_LEN));
  assign w_conf_last = (r_state == ST_LOAD_CONF) && (r_cnt == r_conf_len - 6'd1);
  assign w_run_en    = (r_state == ST_RUN) && !start;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Load commands come straight off the ROM data bus the cycle it is valid.
  always_comb begin
    w_next = r_state;
    action = r_push.action;
    index  = '0;
    mindex = r_push.mindex;
    din    = r_push.din;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD_PROG;
      ST_LOAD_PROG: begin
        if (w_prog_last) w_next = (r_conf_len == '0) ? ST_RUN : ST_LOAD_CONF;
        action = (r_cnt != '0) ? ACT_INSTR : ACT_NONE;
        index  = 5'(r_cnt - 6'd1);
        mindex = '0;
        din    = {16'h0, prog_data};
      end
      ST_LOAD_CONF: begin
        if (w_conf_last) w_next = ST_RUN;
        action = conf_data[35:32];
        mindex = '0;
        din    = conf_data[31:0];
      end
      ST_RUN: if (start) w_next = ST_LOAD_PROG;
      default: w_next = ST_IDLE;
    endcase
  end

  // conf_addr 0 is parked during the program load so config word 0 is ready on entry.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt       <= '0;
      r_conf_len  <= '0;
      r_prog_addr <= '0;
      r_conf_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: if (start) begin
          r_cnt       <= '0;
          r_prog_addr <= '0;
          r_conf_addr <= '0;
          r_conf_len  <= clamp_len(conf_len, MAX_CONF);
        end
        ST_LOAD_PROG: begin
          r_cnt <= w_prog_last ? 6'd0 : r_cnt + 6'd1;
          if (r_cnt < 6'(PROG_LEN - 1)) r_prog_addr <= 5'(r_cnt + 6'd1);
          if (w_prog_last)              r_conf_addr <= 5'd1;
        end
        ST_LOAD_CONF: begin
          r_cnt       <= r_cnt + 6'd1;
          r_conf_addr <= 5'(r_cnt + 6'd2);
        end
        default: ;
      endcase
    end
  end

  pio_rr_arb u_arb (
    .clk     (clk),
    .n_reset (n_reset),
    .i_en    (w_run_en),
    .i_req   (req),
    .i_mask  (tx_full | r_gnt),
    .o_gnt   (w_arb_gnt),
    .o_win   (w_win)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_gnt  <= '0;
      r_push <= '0;
    end else begin
      r_gnt <= w_arb_gnt;
      if (|w_arb_gnt) begin
        r_push.action <= ACT_PUSH;
        r_push.mindex <= w_win;
        r_push.din    <= w_words[w_win];
      end else begin
        r_push.action <= ACT_NONE;
      end
    end
  end

  assign gnt       = r_gnt;
  assign ready     = (r_state == ST_RUN);
  assign prog_addr = r_prog_addr;
  assign conf_addr = r_conf_addr;
endmodule

// File: tb/tb_pio_host_ctrl.sv
// Directed bench for pio_host_ctrl: load sequencing, arbitration fairness, back-pressure, reset/restart.
module tb_pio_host_ctrl;
  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   prog_addr;
  logic [15:0]  prog_data = '0;
  logic [4:0]   conf_addr;
  logic [35:0]  conf_data = '0;
  logic [5:0]   conf_len = 6'd6;
  logic [3:0]   req = '0;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic [3:0]   tx_full = '0;
  logic [3:0]   action;
  logic [4:0]   index;
  logic [1:0]   mindex;
  logic [31:0]  din;
  logic         ready;

  logic [31:0] words [4] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
  int n_cmp = 0;
  int n_bad = 0;

  assign req_data = {words[3], words[2], words[1], words[0]};

  always #5 clk = ~clk;

  pio_host_ctrl #(.PROG_LEN(32), .MAX_CONF(32)) dut (
    .clk(clk), .n_reset(n_reset), .start(start),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .conf_addr(conf_addr), .conf_data(conf_data), .conf_len(conf_len),
    .req(req), .req_data(req_data), .gnt(gnt), .tx_full(tx_full),
    .action(action), .index(index), .mindex(mindex), .din(din), .ready(ready)
  );

  function automatic logic [35:0] conf_word(input logic [4:0] j);
    return {4'h8 | {1'b0, j[2:0]}, 32'hC0F0_0000 + 32'(j)};
  endfunction

  // Synchronous ROMs: data valid the cycle after the address.
  always @(posedge clk) begin
    prog_data <= 16'h1000 + 16'(prog_addr);
    conf_data <= conf_word(conf_addr);
  end

  // Expected {action,index,mindex,din} of the n-th load command.
  function automatic logic [42:0] exp_cmd(input int n);
    logic [35:0] w;
    if (n < 32) return {4'd1, 5'(n), 2'd0, 32'h1000 + 32'(n)};
    w = conf_word(5'(n - 32));
    return {w[35:32], 5'd0, 2'd0, w[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after start was sampled; runs until the first RUN cycle.
  task automatic load_check(input string tag, input int nconf, input int ign_at);
    int ncmd  = 0;
    int rdy_t = -1;
    bit gbad  = 1'b0;
    for (int t = 0; t <= 33 + nconf; t++) begin
      if (t == 0)  chk({tag, " addr0"}, 64'(prog_addr), 64'd0);
      if (t == 10) chk({tag, " addr10"}, 64'(prog_addr), 64'd10);
      if (!ready && action != 4'd0) begin
        chk({tag, " cmd"}, 64'({action, index, mindex, din}), 64'(exp_cmd(ncmd)));
        chk({tag, " cmd_cycle"}, 64'(t), 64'(ncmd + 1));
        ncmd++;
      end
      if (ready && rdy_t < 0) begin
        rdy_t = t;
        chk({tag, " run_action0"}, 64'(action), 64'd0);
      end
      if (!ready && gnt != 4'd0) gbad = 1'b1;
      start = (t == ign_at);
      tick();
    end
    start = 1'b0;
    chk({tag, " ncmds"}, 64'(ncmd), 64'(32 + nconf));
    chk({tag, " ready_cycle"}, 64'(rdy_t), 64'(33 + nconf));
    chk({tag, " no_gnt_in_load"}, 64'(gbad), 64'd0);
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_outputs", 64'({ready, gnt, action, index, mindex, din, prog_addr, conf_addr}), 64'd0);
    n_reset = 1'b1;
    repeat (2) tick();
    chk("idle_no_start", 64'({ready, action, prog_addr}), 64'd0);

    // Full load with 6 config entries; a start during LOAD_CONF must be ignored.
    conf_len = 6'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_check("ld6", 6, 35);

    // Fairness: all four requesting.
    req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_gnt", 64'(gnt), 64'(4'b0001 << (i % 4)));
      chk("rr_push", 64'({action, mindex, din}), 64'({4'd4, 2'(i % 4), words[i % 4]}));
    end
    req = 4'h0;
    tick();
    chk("idle_hold", 64'({gnt, action, mindex, din}), 64'({4'd0, 4'd0, 2'd3, words[3]}));

    // Back-pressure on machine 0.
    req = 4'b0001;
    tx_full = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_full_gnt", 64'(gnt), 64'd0);
    end
    tx_full = 4'b0000;
    tick();
    chk("bp_release", 64'({gnt, action, mindex, din}), 64'({4'b0001, 4'd4, 2'd0, words[0]}));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("bp_alternate", 64'(gnt), (k % 2 == 0) ? 64'd0 : 64'd1);
    end

    // Start in RUN with a request pending: pushes stop, reload begins.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart", 64'({gnt, action, ready, prog_addr}), 64'd0);
    for (int t = 1; t <= 11; t++) begin
      tick();
      if (t == 11) chk("instr10", 64'({action, index, din}), 64'({4'd1, 5'd10, 32'h100A}));
    end

    // Reset mid-load: outputs clear without waiting for a clock.
    n_reset = 1'b0;
    #1;
    chk("async_reset", 64'({ready, gnt, action, index, mindex, din, prog_addr, conf_addr}), 64'd0);
    tick();
    n_reset = 1'b1;
    repeat (2) tick();
    chk("no_resume", 64'({ready, gnt, action, prog_addr}), 64'd0);

    // Reload with no config; the held request is served once RUN is reached.
    conf_len = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    load_check("ld0", 0, -1);
    chk("held_req", 64'({gnt, action, mindex, din}), 64'({4'b0001, 4'd4, 2'd0, words[0]}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
